// File: rtl/picosoc_bus_pkg.sv
// -----------------------------------------------------------------------------
// picosoc_bus_pkg
// Shared definitions for the picosoc single-master bus fabric:
//   - bus_state_e      : transfer FSM encoding (IDLE / REQ / RESP)
//   - MAX_NSLAVES      : upper bound on the number of slave ports
//   - SEL_W            : width of a slave index
//   - ERR_RDATA_DEFAULT: read data returned on a decode miss or timeout
//   - slot32()         : extract 32-bit slot i from a packed slot vector
// -----------------------------------------------------------------------------
package picosoc_bus_pkg;

    localparam int MAX_NSLAVES = 16;
    localparam int SEL_W       = 4;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // Slot i occupies bits [32*i +: 32] of a packed vector sized for MAX_NSLAVES.
    function automatic logic [31:0] slot32(input logic [MAX_NSLAVES*32-1:0] vec, input int idx);
        return vec[32*idx +: 32];
    endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// -----------------------------------------------------------------------------
// picosoc_bus_fabric_if
// Bundles the picorv32 native memory port (m_*) and the fan-out slave side
// (s_*) of the bus fabric.
//   modport master : CPU side     - drives m_valid/m_instr/m_addr/m_wdata/m_wstrb
//   modport slave  : fabric side  - answers the CPU, drives the slave requests
//   modport periph : peripherals  - receive s_* requests, return s_ready/s_rdata
// Parameter NSLAVES sizes s_valid, s_ready and the packed s_rdata vector.
// -----------------------------------------------------------------------------
interface picosoc_bus_fabric_if #(
    parameter int NSLAVES = 4
) ();

    logic                   m_valid;
    logic                   m_instr;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic                   m_ready;
    logic [31:0]            m_rdata;

    logic [NSLAVES-1:0]     s_valid;
    logic [NSLAVES-1:0]     s_ready;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [NSLAVES*32-1:0]  s_rdata;

    modport master (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    modport periph (
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

endinterface

// File: rtl/picosoc_bus_decode.sv
// -----------------------------------------------------------------------------
// picosoc_bus_decode
// Combinational address decoder. Slave i is hit when
// (addr & SLV_MASK[i]) == SLV_BASE[i]. When windows overlap the lowest index
// wins.
//   addr : in  32      address to decode
//   hit  : out 1       at least one window matches
//   sel  : out SEL_W   index of the lowest matching slave (0 when no hit)
// -----------------------------------------------------------------------------
module picosoc_bus_decode
    import picosoc_bus_pkg::*;
#(
    parameter int                    NSLAVES  = 4,
    parameter logic [NSLAVES*32-1:0] SLV_BASE = {NSLAVES{32'h0000_0000}},
    parameter logic [NSLAVES*32-1:0] SLV_MASK = {NSLAVES{32'hFFFF_FFFF}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    logic [MAX_NSLAVES*32-1:0] base_ext;
    logic [MAX_NSLAVES*32-1:0] mask_ext;

    // Priority compare: scanning from the top down lets the lowest index overwrite.
    always_comb begin
        base_ext                    = '0;
        mask_ext                    = '0;
        base_ext[NSLAVES*32-1:0]    = SLV_BASE;
        mask_ext[NSLAVES*32-1:0]    = SLV_MASK;
        hit                         = 1'b0;
        sel                         = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((addr & slot32(mask_ext, i)) == slot32(base_ext, i)) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end else begin
                hit = hit;
                sel = sel;
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// -----------------------------------------------------------------------------
// picosoc_bus_fabric
// Single-master, NSLAVES-port fabric between the picorv32 native memory port
// and the SoC peripherals. Table-driven base/mask decode, registered one-hot
// slave requests, decode-miss error response and an optional watchdog.
//
// Ports
//   clk      : in   system clock
//   reset    : in   asynchronous reset, active-high
//   bus      : picosoc_bus_fabric_if.slave (m_* from the CPU, s_* to slaves)
//   err_irq  : out  one-cycle pulse on decode miss or timeout
//   err_addr : out  address of the most recent errored access, bit0 = m_instr
//
// Build option
//   PICOSOC_BUS_TIMEOUT_EN : when defined, a REQ that sees no s_ready within
//                            TIMEOUT_CYCLES cycles is terminated with
//                            ERR_RDATA and an err_irq pulse.
//
// Transfer: IDLE -(hit)-> REQ -(s_ready)-> RESP -> IDLE, IDLE -(miss)-> RESP.
// m_ready pulses one cycle after RESP; IDLE ignores m_valid while that pulse
// is out because the master has not yet had a chance to drop its request.
// -----------------------------------------------------------------------------
module picosoc_bus_fabric
    import picosoc_bus_pkg::*;
#(
    parameter int                    NSLAVES        = 4,
    parameter logic [NSLAVES*32-1:0] SLV_BASE       = {NSLAVES{32'h0000_0000}},
    parameter logic [NSLAVES*32-1:0] SLV_MASK       = {NSLAVES{32'hFFFF_FFFF}},
    parameter logic [31:0]           ERR_RDATA      = ERR_RDATA_DEFAULT,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    picosoc_bus_fabric_if.slave  bus,
    output logic                 err_irq,
    output logic [31:0]          err_addr
);

    bus_state_e          state_r;
    bus_state_e          state_nx;

    logic [NSLAVES-1:0]  s_valid_r;
    logic [31:0]         s_addr_r;
    logic [31:0]         s_wdata_r;
    logic [3:0]          s_wstrb_r;
    logic                instr_r;
    logic                m_ready_r;
    logic [31:0]         m_rdata_r;
    logic                err_irq_r;
    logic [31:0]         err_addr_r;

    logic                dec_hit_s;
    logic [SEL_W-1:0]    dec_sel_s;
    logic [NSLAVES-1:0]  sel_onehot_s;
    logic [31:0]         slv_rdata_s;
    logic                slv_ready_s;
    logic                wd_expire_s;

    logic                take_req_s;
    logic                miss_s;
    logic                done_ok_s;
    logic                timeout_s;

    picosoc_bus_decode #(
        .NSLAVES  (NSLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (bus.m_addr),
        .hit  (dec_hit_s),
        .sel  (dec_sel_s)
    );

    // Decoded index to one-hot request; read data and ready of the active slave only.
    always_comb begin
        sel_onehot_s = '0;
        slv_rdata_s  = 32'h0000_0000;
        for (int i = 0; i < NSLAVES; i++) begin
            sel_onehot_s[i] = (dec_sel_s == SEL_W'(i));
            slv_rdata_s     = slv_rdata_s | ({32{s_valid_r[i]}} & bus.s_rdata[32*i +: 32]);
        end
        slv_ready_s = |(bus.s_ready & s_valid_r);
    end

`ifdef PICOSOC_BUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_r;

    // Watchdog: cleared on entry to REQ, counts every REQ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if (take_req_s) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_REQ) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign wd_expire_s = (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit parameter has no consumer; fold it away.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign wd_expire_s        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next state and per-cycle transfer events; s_ready wins over an expiring watchdog.
    always_comb begin
        state_nx   = state_r;
        take_req_s = 1'b0;
        miss_s     = 1'b0;
        done_ok_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.m_valid && !m_ready_r) begin
                    if (dec_hit_s) begin
                        state_nx   = ST_REQ;
                        take_req_s = 1'b1;
                    end else begin
                        state_nx   = ST_RESP;
                        miss_s     = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (slv_ready_s) begin
                    state_nx  = ST_RESP;
                    done_ok_s = 1'b1;
                end else if (wd_expire_s) begin
                    state_nx  = ST_RESP;
                    timeout_s = 1'b1;
                end else begin
                    state_nx  = ST_REQ;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: request capture, slave strobes, response and error capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid_r  <= '0;
            s_addr_r   <= 32'h0000_0000;
            s_wdata_r  <= 32'h0000_0000;
            s_wstrb_r  <= 4'b0000;
            instr_r    <= 1'b0;
            m_ready_r  <= 1'b0;
            m_rdata_r  <= 32'h0000_0000;
            err_irq_r  <= 1'b0;
            err_addr_r <= 32'h0000_0000;
        end else begin
            if (take_req_s || miss_s) begin
                s_addr_r  <= bus.m_addr;
                s_wdata_r <= bus.m_wdata;
                s_wstrb_r <= bus.m_wstrb;
                instr_r   <= bus.m_instr;
            end else begin
                s_addr_r  <= s_addr_r;
                s_wdata_r <= s_wdata_r;
                s_wstrb_r <= s_wstrb_r;
                instr_r   <= instr_r;
            end

            if (take_req_s) begin
                s_valid_r <= sel_onehot_s;
            end else if (done_ok_s || timeout_s) begin
                s_valid_r <= '0;
            end else begin
                s_valid_r <= s_valid_r;
            end

            if (miss_s || timeout_s) begin
                m_rdata_r <= ERR_RDATA;
            end else if (done_ok_s) begin
                m_rdata_r <= slv_rdata_s;
            end else begin
                m_rdata_r <= m_rdata_r;
            end

            // A miss reports the live request; a timeout reports the captured one.
            if (miss_s) begin
                err_addr_r <= {bus.m_addr[31:1], bus.m_instr};
            end else if (timeout_s) begin
                err_addr_r <= {s_addr_r[31:1], instr_r};
            end else begin
                err_addr_r <= err_addr_r;
            end

            m_ready_r <= (state_r == ST_RESP);
            err_irq_r <= miss_s || timeout_s;
        end
    end

    assign bus.s_valid = s_valid_r;
    assign bus.s_addr  = s_addr_r;
    assign bus.s_wdata = s_wdata_r;
    assign bus.s_wstrb = s_wstrb_r;
    assign bus.m_ready = m_ready_r;
    assign bus.m_rdata = m_rdata_r;
    assign err_irq     = err_irq_r;
    assign err_addr    = err_addr_r;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_picosoc_bus_fabric
// Directed, table-driven bench for picosoc_bus_fabric with four slaves:
//   slave0 0x0000_0000 / 0xFFFF_F000   slave1 0x0100_0000 / 0xFF00_0000
//   slave2 0x0200_0000 / 0xFF00_0000   slave3 0x0000_0000 / 0xFFFF_0000
// slave3 overlaps slave0 in the low 4 KiB; 0x0000_8000 reaches slave3 only.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_picosoc_bus_fabric;

    localparam int NS = 4;
    localparam logic [NS*32-1:0] BASES = {32'h0000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASKS = {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_F000};
    localparam logic [31:0]      ERRD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        err_irq;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    picosoc_bus_fabric_if #(.NSLAVES(NS)) bus ();

    picosoc_bus_fabric #(
        .NSLAVES        (NS),
        .SLV_BASE       (BASES),
        .SLV_MASK       (MASKS),
        .ERR_RDATA      (ERRD),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .err_irq  (err_irq),
        .err_addr (err_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          waitc;   // slave wait cycles before s_ready
        logic        drop;    // master drops m_valid in cycle 2
        logic [3:0]  sel;     // expected one-hot s_valid (0 on miss)
        int          lat;     // expected cycle of m_ready after m_valid rise
        int          svc;     // expected number of cycles with s_valid high
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_err_addr = 32'h0000_0000;
    vec_t        vecs[8];

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic instr, input int waitc, input logic drop, input logic [3:0] sel,
                                input int lat, input int svc, input logic [31:0] rdata, input logic err);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.instr = instr; v.waitc = waitc;
        v.drop = drop; v.sel = sel; v.lat = lat; v.svc = svc; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer, acting as master and as the expected slave.
    task automatic run_xfer(input vec_t v, input string tag);
        int          first_ready  = -1;
        int          ready_pulses = 0;
        int          err_pulses   = 0;
        int          sv_cycles    = 0;
        int          wcnt         = 0;
        logic [3:0]  sv_seen      = 4'b0000;
        logic [31:0] rdata_got    = 32'h0000_0000;
        logic        stable       = 1'b1;
        logic [31:0] ad0          = 32'h0000_0000;
        logic [31:0] wd0          = 32'h0000_0000;
        logic [3:0]  ws0          = 4'b0000;

        @(negedge clk);
        bus.m_valid = 1'b1;
        bus.m_instr = v.instr;
        bus.m_addr  = v.addr;
        bus.m_wdata = v.wdata;
        bus.m_wstrb = v.wstrb;
        bus.s_ready = ~v.sel;      // unselected slaves shout ready; must be ignored
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.m_ready) begin
                ready_pulses++;
                if (first_ready < 0) begin
                    first_ready = c;
                    rdata_got   = bus.m_rdata;
                end
            end
            if (err_irq) err_pulses++;
            if (bus.s_valid != 4'b0000) begin
                sv_seen = sv_seen | bus.s_valid;
                if (sv_cycles == 0) begin
                    ad0 = bus.s_addr; wd0 = bus.s_wdata; ws0 = bus.s_wstrb;
                end else if (bus.s_addr !== ad0 || bus.s_wdata !== wd0 || bus.s_wstrb !== ws0) begin
                    stable = 1'b0;
                end
                sv_cycles++;
            end
            // Master keeps valid through the m_ready cycle, then drops it.
            if (first_ready >= 0 && c > first_ready) bus.m_valid = 1'b0;
            if (v.drop && c == 2) bus.m_valid = 1'b0;
            if ((bus.s_valid & v.sel) != 4'b0000) begin
                bus.s_ready = ~v.sel | ((wcnt == v.waitc) ? v.sel : 4'b0000);
                wcnt++;
            end else begin
                bus.s_ready = ~v.sel;
            end
            if (first_ready >= 0 && c >= first_ready + 3) break;
        end
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0000;
        if (v.err) model_err_addr = {v.addr[31:1], v.instr};

        check({tag, " latency"},      32'(first_ready),  32'(v.lat));
        check({tag, " m_rdata"},      rdata_got,         v.rdata);
        check({tag, " s_valid sel"},  {28'h0, sv_seen},  {28'h0, v.sel});
        check({tag, " s_valid len"},  32'(sv_cycles),    32'(v.svc));
        check({tag, " ready pulses"}, 32'(ready_pulses), 32'd1);
        check({tag, " err pulses"},   32'(err_pulses),   v.err ? 32'd1 : 32'd0);
        check({tag, " s_* stable"},   {31'h0, stable},   32'd1);
        check({tag, " s_addr"},       bus.s_addr,        v.addr);
        check({tag, " s_wdata"},      bus.s_wdata,       v.wdata);
        check({tag, " s_wstrb"},      {28'h0, bus.s_wstrb}, {28'h0, v.wstrb});
        check({tag, " err_addr"},     err_addr,          model_err_addr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " m_ready"},  {31'h0, bus.m_ready}, 32'd0);
        check({tag, " s_valid"},  {28'h0, bus.s_valid}, 32'd0);
        check({tag, " err_irq"},  {31'h0, err_irq},     32'd0);
        check({tag, " m_rdata"},  bus.m_rdata,          32'd0);
        check({tag, " s_addr"},   bus.s_addr,           32'd0);
        check({tag, " s_wdata"},  bus.s_wdata,          32'd0);
        check({tag, " s_wstrb"},  {28'h0, bus.s_wstrb}, 32'd0);
        check({tag, " err_addr"}, err_addr,             32'd0);
    endtask

    initial begin
        //                addr          wdata         strb     ins   wt drop  sel      lat svc rdata          err
        vecs[0] = mk(32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 0, 1'b0, 4'b0001, 3, 1, 32'h1234_5678, 1'b0);
        vecs[1] = mk(32'h0200_0008, 32'h0000_00A5, 4'b0001, 1'b0, 5, 1'b0, 4'b0100, 8, 6, 32'h2222_2222, 1'b0);
        vecs[2] = mk(32'h7000_0000, 32'h0000_0000, 4'b0000, 1'b0, 0, 1'b0, 4'b0000, 2, 0, ERRD,          1'b1);
        vecs[3] = mk(32'h0000_0100, 32'h0000_0000, 4'b0000, 1'b0, 1, 1'b0, 4'b0001, 4, 2, 32'h1234_5678, 1'b0);
        vecs[4] = mk(32'h0000_8000, 32'h0000_0000, 4'b0000, 1'b0, 2, 1'b0, 4'b1000, 5, 3, 32'h3333_3333, 1'b0);
        vecs[5] = mk(32'h7000_0000, 32'h0000_0000, 4'b0000, 1'b1, 0, 1'b0, 4'b0000, 2, 0, ERRD,          1'b1);
        vecs[6] = mk(32'h0100_0004, 32'hCAFE_F00D, 4'b1111, 1'b0, 0, 1'b0, 4'b0010, 3, 1, 32'h1111_1111, 1'b0);
        vecs[7] = mk(32'h0000_0020, 32'h0000_0000, 4'b0000, 1'b0, 2, 1'b1, 4'b0001, 5, 3, 32'h1234_5678, 1'b0);

        reset       = 1'b1;
        bus.m_valid = 1'b0;
        bus.m_instr = 1'b0;
        bus.m_addr  = 32'h0000_0000;
        bus.m_wdata = 32'h0000_0000;
        bus.m_wstrb = 4'b0000;
        bus.s_ready = 4'b0000;
        bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef PICOSOC_BUS_TIMEOUT_EN
        // slave1 never answers: 16 REQ cycles, then error response.
        run_xfer(mk(32'h0100_0020, 32'h0000_0000, 4'b0000, 1'b0, 1000, 1'b0, 4'b0010, 18, 16, ERRD, 1'b1), "timeout");
        // s_ready in the 16th REQ cycle beats the watchdog.
        run_xfer(mk(32'h0100_0024, 32'h0000_0000, 4'b0000, 1'b0, 15, 1'b0, 4'b0010, 18, 16, 32'h1111_1111, 1'b0), "ready_at_limit");
`else
        // Without the watchdog a slow slave is simply waited for.
        run_xfer(mk(32'h0100_0020, 32'h0000_0000, 4'b0000, 1'b0, 40, 1'b0, 4'b0010, 43, 41, 32'h1111_1111, 1'b0), "long_wait");
`endif

        // Asynchronous reset in the middle of a REQ.
        @(negedge clk);
        bus.m_valid = 1'b1;
        bus.m_instr = 1'b0;
        bus.m_addr  = 32'h0100_0010;
        bus.m_wdata = 32'h0000_0000;
        bus.m_wstrb = 4'b0000;
        bus.s_ready = 4'b0000;
        repeat (3) @(negedge clk);
        check("mid_req s_valid", {28'h0, bus.s_valid}, 32'h0000_0002);
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        bus.m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_err_addr = 32'h0000_0000;
        @(negedge clk);
        run_xfer(vecs[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
